// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
// Optional statistics counters are enabled by defining IFU_STATS_EN.
package fetch_pkg;

    localparam int XLEN        = 32;
    localparam int INSTR_BYTES = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        FETCH = 2'b01,
        FLUSH = 2'b10
    } fetch_state_t;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Instruction/PC buffer with a registered head entry and single-cycle flush.
// Push while full is accepted only together with a pop.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int  DEPTH   = 4,
    parameter type entry_t = fetch_entry_t
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  entry_t                 push_data,
    input  logic                   pop,
    input  logic                   flush,
    output logic                   head_valid,
    output entry_t                 head_data,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    entry_t             mem_r [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_r;
    logic [PTR_W-1:0]   rd_ptr_r;
    logic [CNT_W-1:0]   count_r;
    logic               head_valid_r;
    entry_t             head_data_r;

    logic               do_push_s;
    logic               do_pop_s;
    logic [PTR_W-1:0]   wr_ptr_nxt_s;
    logic [PTR_W-1:0]   rd_ptr_nxt_s;
    logic [CNT_W-1:0]   count_nxt_s;
    entry_t             head_nxt_s;

    // Next pointers, occupancy and the entry that becomes the head
    always_comb begin
        do_pop_s  = pop && (count_r != {CNT_W{1'b0}});
        do_push_s = push && !flush && ((count_r != CNT_W'(DEPTH)) || do_pop_s);
        if (flush) begin
            wr_ptr_nxt_s = {PTR_W{1'b0}};
            rd_ptr_nxt_s = {PTR_W{1'b0}};
            count_nxt_s  = {CNT_W{1'b0}};
        end else begin
            wr_ptr_nxt_s = wr_ptr_r + PTR_W'(do_push_s);
            rd_ptr_nxt_s = rd_ptr_r + PTR_W'(do_pop_s);
            count_nxt_s  = count_r + CNT_W'(do_push_s) - CNT_W'(do_pop_s);
        end
        // A word written into the slot that becomes the head bypasses storage
        if (do_push_s && (wr_ptr_r == rd_ptr_nxt_s)) begin
            head_nxt_s = push_data;
        end else begin
            head_nxt_s = mem_r[rd_ptr_nxt_s];
        end
    end

    // Storage, pointers and registered head
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
            wr_ptr_r     <= {PTR_W{1'b0}};
            rd_ptr_r     <= {PTR_W{1'b0}};
            count_r      <= {CNT_W{1'b0}};
            head_valid_r <= 1'b0;
            head_data_r  <= '0;
        end else begin
            if (do_push_s) begin
                mem_r[wr_ptr_r] <= push_data;
            end
            wr_ptr_r     <= wr_ptr_nxt_s;
            rd_ptr_r     <= rd_ptr_nxt_s;
            count_r      <= count_nxt_s;
            head_valid_r <= (count_nxt_s != {CNT_W{1'b0}});
            if (count_nxt_s != {CNT_W{1'b0}}) begin
                head_data_r <= head_nxt_s;
            end
        end
    end

    assign head_valid = head_valid_r;
    assign head_data  = head_data_r;
    assign count      = count_r;

endmodule

// File: rtl/instr_fetch_unit.sv
// Decoupled in-order instruction fetch with credit-based issue and redirect flush.
// Define IFU_STATS_EN to add the stat_fetched/stat_flushed counters.
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter int               WIDTH    = 32,
    parameter int               DEPTH    = 4,
    parameter logic [WIDTH-1:0] RESET_PC = {WIDTH{1'b0}}
) (
    input  logic             CLK,
    input  logic             rst,
    input  logic             redirect_valid,
    input  logic [WIDTH-1:0] redirect_pc,
    output logic             mem_req_valid,
    input  logic             mem_req_ready,
    output logic [WIDTH-1:0] mem_req_addr,
    input  logic             mem_rsp_valid,
    input  logic [WIDTH-1:0] mem_rsp_data,
    output logic             instr_valid,
    input  logic             instr_ready,
    output logic [WIDTH-1:0] instr,
    output logic [WIDTH-1:0] instr_pc,
    output logic             busy
`ifdef IFU_STATS_EN
    ,
    output logic [31:0]      stat_fetched,
    output logic [31:0]      stat_flushed
`endif
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int SUM_W = CNT_W + 1;

    typedef struct packed {
        logic [WIDTH-1:0] instr;
        logic [WIDTH-1:0] pc;
    } entry_t;

    fetch_state_t       state_r;
    logic [WIDTH-1:0]   fetch_pc_r;
    logic [WIDTH-1:0]   rsp_pc_r;
    logic [CNT_W-1:0]   outstanding_r;
    logic [CNT_W-1:0]   drop_cnt_r;
    logic               req_valid_r;
    logic [WIDTH-1:0]   req_addr_r;
    logic               busy_r;

    logic               req_fire_s;
    logic               rsp_fire_s;
    logic               rsp_drop_s;
    logic               push_s;
    logic               pop_s;
    logic [WIDTH-1:0]   target_s;
    logic [CNT_W-1:0]   out_nxt_s;
    logic [CNT_W-1:0]   drop_nxt_s;
    logic [CNT_W-1:0]   count_nxt_s;
    logic [WIDTH-1:0]   fetch_pc_nxt_s;
    logic [WIDTH-1:0]   rsp_pc_nxt_s;
    fetch_state_t       state_nxt_s;
    logic               req_valid_nxt_s;
    entry_t             push_entry_s;
    logic               head_valid_s;
    entry_t             head_data_s;
    logic [CNT_W-1:0]   fifo_count_s;

    // Handshakes and next-state values for counters, PCs and FSM
    always_comb begin
        req_fire_s   = req_valid_r && mem_req_ready;
        // Responses with nothing outstanding (e.g. left over from before reset) are ignored
        rsp_fire_s   = mem_rsp_valid && (outstanding_r != {CNT_W{1'b0}});
        rsp_drop_s   = rsp_fire_s && (redirect_valid || (drop_cnt_r != {CNT_W{1'b0}}));
        push_s       = rsp_fire_s && !rsp_drop_s;
        pop_s        = head_valid_s && instr_ready;
        target_s     = redirect_pc & ~{{(WIDTH-2){1'b0}}, 2'b11};
        push_entry_s = '{instr: mem_rsp_data, pc: rsp_pc_r};

        out_nxt_s = outstanding_r + CNT_W'(req_fire_s) - CNT_W'(rsp_fire_s);

        if (redirect_valid) begin
            drop_nxt_s     = out_nxt_s;
            fetch_pc_nxt_s = target_s;
            rsp_pc_nxt_s   = target_s;
            count_nxt_s    = {CNT_W{1'b0}};
        end else begin
            if (rsp_fire_s && (drop_cnt_r != {CNT_W{1'b0}})) begin
                drop_nxt_s = drop_cnt_r - CNT_W'(1);
            end else begin
                drop_nxt_s = drop_cnt_r;
            end
            fetch_pc_nxt_s = req_fire_s ? (fetch_pc_r + WIDTH'(INSTR_BYTES)) : fetch_pc_r;
            rsp_pc_nxt_s   = push_s ? (rsp_pc_r + WIDTH'(INSTR_BYTES)) : rsp_pc_r;
            count_nxt_s    = fifo_count_s + CNT_W'(push_s) - CNT_W'(pop_s);
        end

        case (state_r)
            IDLE:    state_nxt_s = FETCH;
            FETCH:   state_nxt_s = (redirect_valid && (out_nxt_s != {CNT_W{1'b0}})) ? FLUSH : FETCH;
            FLUSH:   state_nxt_s = (!redirect_valid && (drop_nxt_s == {CNT_W{1'b0}})) ? FETCH : FLUSH;
            default: state_nxt_s = IDLE;
        endcase

        // Credit rule: buffered plus in-flight words never exceed the FIFO depth
        req_valid_nxt_s = (state_nxt_s == FETCH) &&
                          (({1'b0, count_nxt_s} + {1'b0, out_nxt_s}) < SUM_W'(DEPTH));
    end

    // FSM, fetch/response PCs, credit counters and registered request outputs
    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) begin
            state_r       <= IDLE;
            fetch_pc_r    <= RESET_PC;
            rsp_pc_r      <= RESET_PC;
            outstanding_r <= {CNT_W{1'b0}};
            drop_cnt_r    <= {CNT_W{1'b0}};
            req_valid_r   <= 1'b0;
            req_addr_r    <= {WIDTH{1'b0}};
            busy_r        <= 1'b0;
        end else begin
            state_r       <= state_nxt_s;
            fetch_pc_r    <= fetch_pc_nxt_s;
            rsp_pc_r      <= rsp_pc_nxt_s;
            outstanding_r <= out_nxt_s;
            drop_cnt_r    <= drop_nxt_s;
            req_valid_r   <= req_valid_nxt_s;
            req_addr_r    <= fetch_pc_nxt_s;
            busy_r        <= (out_nxt_s != {CNT_W{1'b0}}) || (state_nxt_s == FLUSH);
        end
    end

    fetch_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clk        (CLK),
        .rst_n      (rst),
        .push       (push_s),
        .push_data  (push_entry_s),
        .pop        (pop_s),
        .flush      (redirect_valid),
        .head_valid (head_valid_s),
        .head_data  (head_data_s),
        .count      (fifo_count_s)
    );

    assign mem_req_valid = req_valid_r;
    assign mem_req_addr  = req_addr_r;
    assign instr_valid   = head_valid_s;
    assign instr         = head_data_s.instr;
    assign instr_pc      = head_data_s.pc;
    assign busy          = busy_r;

`ifdef IFU_STATS_EN
    logic [31:0] stat_fetched_r;
    logic [31:0] stat_flushed_r;
    logic [31:0] flush_inc_s;

    // Discards: buffered words lost to a redirect (a same-cycle pop still counts as fetched) plus dropped responses
    always_comb begin
        if (redirect_valid) begin
            flush_inc_s = 32'(fifo_count_s) - 32'(pop_s) + 32'(rsp_drop_s);
        end else begin
            flush_inc_s = 32'(rsp_drop_s);
        end
    end

    // Statistics counters, wrapping at 2^32
    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) begin
            stat_fetched_r <= 32'd0;
            stat_flushed_r <= 32'd0;
        end else begin
            stat_fetched_r <= stat_fetched_r + 32'(pop_s);
            stat_flushed_r <= stat_flushed_r + flush_inc_s;
        end
    end

    assign stat_fetched = stat_fetched_r;
    assign stat_flushed = stat_flushed_r;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: memory model with configurable latency and a PC-stream scoreboard.
// Stats checks are compiled in when IFU_STATS_EN is defined.
module tb_instr_fetch_unit;

    logic        CLK = 1'b0;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_req_addr;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_data;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        busy;
`ifdef IFU_STATS_EN
    logic [31:0] stat_fetched;
    logic [31:0] stat_flushed;
`endif

    always #5 CLK = ~CLK;

    instr_fetch_unit dut (
        .CLK            (CLK),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_addr   (mem_req_addr),
        .mem_rsp_valid  (mem_rsp_valid),
        .mem_rsp_data   (mem_rsp_data),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .busy           (busy)
`ifdef IFU_STATS_EN
        ,
        .stat_fetched   (stat_fetched),
        .stat_flushed   (stat_flushed)
`endif
    );

    int          checks = 0;
    int          errors = 0;
    logic [31:0] pend_addr[$];
    int          pend_due[$];
    int          cyc;
    int          lat;
    logic        req_ok;
    int          req_budget;
    logic        iready_cfg;
    logic        junk_rsp;
    logic [31:0] exp_req;
    logic [31:0] exp_pc;
    int          n_hs;
    int          n_pops;
    int          n_rsps;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock cycle: memory model, request/pop scoreboard, optional redirect
    task automatic step(input logic redir, input logic [31:0] rpc);
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = 32'h0;
        if (junk_rsp) begin
            mem_rsp_valid = 1'b1;
            mem_rsp_data  = 32'hDEAD_BEEF;
            junk_rsp      = 1'b0;
        end else if (pend_addr.size() > 0 && pend_due[0] <= cyc) begin
            mem_rsp_valid = 1'b1;
            mem_rsp_data  = ~pend_addr[0];
            void'(pend_addr.pop_front());
            void'(pend_due.pop_front());
            n_rsps++;
        end
        mem_req_ready = req_ok && (req_budget > 0);
        if (mem_req_valid && mem_req_ready) begin
            check_eq("req_addr", mem_req_addr, exp_req);
            exp_req = exp_req + 32'd4;
            pend_addr.push_back(mem_req_addr);
            pend_due.push_back(cyc + lat);
            n_hs++;
            req_budget--;
        end
        instr_ready = iready_cfg;
        if (instr_valid && instr_ready) begin
            check_eq("pop_pc", instr_pc, exp_pc);
            check_eq("pop_instr", instr, ~exp_pc);
            exp_pc = exp_pc + 32'd4;
            n_pops++;
        end
        redirect_valid = redir;
        redirect_pc    = rpc;
        if (redir) begin
            exp_req = rpc & 32'hFFFF_FFFC;
            exp_pc  = rpc & 32'hFFFF_FFFC;
        end
        @(negedge CLK);
        cyc++;
        redirect_valid = 1'b0;
    endtask

    task automatic release_reset();
        rst        = 1'b1;
        cyc        = 0;
        exp_req    = 32'h0;
        exp_pc     = 32'h0;
        n_hs       = 0;
        n_pops     = 0;
        n_rsps     = 0;
        req_budget = 1000;
        req_ok     = 1'b1;
    endtask

    task automatic do_reset();
        rst            = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        mem_req_ready  = 1'b0;
        mem_rsp_valid  = 1'b0;
        mem_rsp_data   = 32'h0;
        instr_ready    = 1'b0;
        junk_rsp       = 1'b0;
        pend_addr.delete();
        pend_due.delete();
        @(negedge CLK);
        check_eq("rst_req_valid", 32'(mem_req_valid), 32'h0);
        check_eq("rst_req_addr", mem_req_addr, 32'h0);
        check_eq("rst_instr_valid", 32'(instr_valid), 32'h0);
        check_eq("rst_busy", 32'(busy), 32'h0);
        @(negedge CLK);
        release_reset();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 32'h0);
    endtask

    task automatic run_until_valid(input int max_steps);
        for (int i = 0; i < max_steps && !instr_valid; i++) step(1'b0, 32'h0);
        check_eq("wait_instr_valid", 32'(instr_valid), 32'h1);
    endtask

    task automatic run_until_req(input int max_steps);
        for (int i = 0; i < max_steps && !mem_req_valid; i++) step(1'b0, 32'h0);
        check_eq("wait_req_valid", 32'(mem_req_valid), 32'h1);
    endtask

    task automatic drain();
        req_budget = 0;
        iready_cfg = 1'b1;
        for (int i = 0; i < 100 && (pend_addr.size() != 0 || busy || instr_valid); i++) step(1'b0, 32'h0);
        check_eq("drain_busy", 32'(busy), 32'h0);
        check_eq("drain_instr_valid", 32'(instr_valid), 32'h0);
    endtask

    task automatic check_stats();
`ifdef IFU_STATS_EN
        check_eq("stat_fetched", stat_fetched, 32'(n_pops));
        check_eq("stat_flushed", stat_flushed, 32'(n_rsps - n_pops));
`endif
    endtask

    initial begin
        lat        = 1;
        iready_cfg = 1'b0;
        req_ok     = 1'b1;
        req_budget = 1000;
        cyc        = 0;

        // 1: streaming, 1-cycle memory, core always ready
        do_reset();
        lat = 1; iready_cfg = 1'b1;
        check_eq("t1_idle_req", 32'(mem_req_valid), 32'h0);
        step(1'b0, 32'h0);
        check_eq("t1_first_req", 32'(mem_req_valid), 32'h1);
        check_eq("t1_first_addr", mem_req_addr, 32'h0);
        step(1'b0, 32'h0);
        check_eq("t1_no_early_valid", 32'(instr_valid), 32'h0);
        step(1'b0, 32'h0);
        check_eq("t1_latency_valid", 32'(instr_valid), 32'h1);
        check_eq("t1_head_pc", instr_pc, 32'h0);
        check_eq("t1_head_instr", instr, 32'hFFFF_FFFF);
        run(20);
        check_eq("t1_pop_count", 32'(n_pops), 32'd20);

        // 2: core stalled, credit limits issue to DEPTH requests
        do_reset();
        lat = 1; iready_cfg = 1'b0;
        run(12);
        check_eq("t2_req_count", 32'(n_hs), 32'd4);
        check_eq("t2_req_stalled", 32'(mem_req_valid), 32'h0);
        check_eq("t2_head_valid", 32'(instr_valid), 32'h1);
        check_eq("t2_head_pc", instr_pc, 32'h0);
        iready_cfg = 1'b1;
        run(30);
        check_eq("t2_resume_pops", 32'(n_pops >= 20), 32'h1);

        // 3: redirect with three slow responses in flight
        do_reset();
        lat = 5; iready_cfg = 1'b1; req_budget = 3;
        for (int i = 0; i < 10 && n_hs < 3; i++) step(1'b0, 32'h0);
        check_eq("t3_hs", 32'(n_hs), 32'd3);
        check_eq("t3_busy_before", 32'(busy), 32'h1);
        step(1'b1, 32'h0000_0103);
        req_budget = 1000;
        for (int i = 0; i < 3; i++) begin
            check_eq("t3_flush_req_off", 32'(mem_req_valid), 32'h0);
            check_eq("t3_flush_busy", 32'(busy), 32'h1);
            check_eq("t3_flush_no_instr", 32'(instr_valid), 32'h0);
            step(1'b0, 32'h0);
        end
        run_until_valid(30);
        check_eq("t3_new_pc", instr_pc, 32'h0000_0100);
        check_eq("t3_new_instr", instr, ~32'h0000_0100);

        // 4: redirect coincides with a response and a request handshake
        do_reset();
        lat = 2; iready_cfg = 1'b1;
        run(8);
        check_eq("t4_req_before", 32'(mem_req_valid), 32'h1);
        check_eq("t4_rsp_due", 32'(pend_due.size() > 0 && pend_due[0] <= cyc), 32'h1);
        step(1'b1, 32'h0000_0200);
        check_eq("t4_busy", 32'(busy), 32'h1);
        check_eq("t4_req_withdrawn", 32'(mem_req_valid), 32'h0);
        check_eq("t4_instr_cleared", 32'(instr_valid), 32'h0);
        run_until_req(20);
        check_eq("t4_restart_addr", mem_req_addr, 32'h0000_0200);
        run_until_valid(20);
        check_eq("t4_new_pc", instr_pc, 32'h0000_0200);
        drain();
        check_stats();

        // 5: asynchronous reset with work in flight, then a stale response
        do_reset();
        lat = 3; iready_cfg = 1'b0;
        run(6);
        #2 rst = 1'b0;
        #1;
        check_eq("t5_async_req_valid", 32'(mem_req_valid), 32'h0);
        check_eq("t5_async_req_addr", mem_req_addr, 32'h0);
        check_eq("t5_async_instr_valid", 32'(instr_valid), 32'h0);
        check_eq("t5_async_instr", instr, 32'h0);
        check_eq("t5_async_instr_pc", instr_pc, 32'h0);
        check_eq("t5_async_busy", 32'(busy), 32'h0);
        pend_addr.delete();
        pend_due.delete();
        @(negedge CLK);
        release_reset();
        lat = 3; iready_cfg = 1'b1; junk_rsp = 1'b1;
        step(1'b0, 32'h0);
        check_eq("t5_stale_ignored", 32'(instr_valid), 32'h0);
        check_eq("t5_restart_req", 32'(mem_req_valid), 32'h1);
        check_eq("t5_restart_addr", mem_req_addr, 32'h0);
        run_until_valid(20);
        check_eq("t5_first_pc", instr_pc, 32'h0);
        check_eq("t5_first_instr", instr, 32'hFFFF_FFFF);

        // 6: fetch address wraps past the top of the address space
        do_reset();
        lat = 1; iready_cfg = 1'b1;
        run(5);
        step(1'b1, 32'hFFFF_FFFE);
        run_until_req(20);
        check_eq("t6_top_addr", mem_req_addr, 32'hFFFF_FFFC);
        step(1'b0, 32'h0);
        check_eq("t6_wrap_addr", mem_req_addr, 32'h0);
        run(10);
        check_eq("t6_wrap_pops", 32'(n_pops >= 10), 32'h1);
        drain();
        check_stats();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
